// File: rtl/onehot_encoder_seq_if.sv
// ----------------------------------------------------------------------------
// onehot_encoder_seq_if : request-vector in / binary-index out handshake bundle
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface onehot_encoder_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] input_vector;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] N;
    logic       out_last;
    logic       zero_err;

    modport slave (
        input  in_valid, input_vector, out_ready,
        output in_ready, out_valid, N, out_last, zero_err
    );

    modport master (
        output in_valid, input_vector, out_ready,
        input  in_ready, out_valid, N, out_last, zero_err
    );
endinterface

`default_nettype wire

// File: rtl/onehot_encoder_seq.sv
// ----------------------------------------------------------------------------
// onehot_encoder_seq : emits the 3-bit index of every set bit of an accepted
//                      8-bit request vector, one index per output handshake
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module onehot_encoder_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire                   clk,
    input  wire                   rst_n,
    onehot_encoder_seq_if.slave   bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [7:0] c_ONE = 8'h01;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       zero_err_q, zero_err_d;

    logic [2:0] w_idx;
    logic       w_last;
    logic       w_accept;
    logic       w_xfer;

    // Index selection looks only at pending_q, so N never depends on inputs.
    if (MSB_FIRST) begin : g_msb_first
        always_comb begin
            w_idx = 3'd0;
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) w_idx = i[2:0];
            end
        end
    end else begin : g_lsb_first
        always_comb begin
            w_idx = 3'd0;
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) w_idx = i[2:0];
            end
        end
    end

    assign w_last   = (pending_q != 8'h00) && ((pending_q & (pending_q - c_ONE)) == 8'h00);
    assign w_accept = (state_q == S_IDLE) && bus.in_valid;
    assign w_xfer   = (state_q == S_EMIT) && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.input_vector != 8'h00) begin
                        pending_d = bus.input_vector;
                        state_d   = S_EMIT;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (w_xfer) begin
                    pending_d = pending_q & ~(c_ONE << w_idx);
                    if (w_last) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= 8'h00;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_err_q <= zero_err_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_EMIT);
    assign bus.N         = w_idx;
    assign bus.out_last  = (state_q == S_EMIT) && w_last;
    assign bus.zero_err  = zero_err_q;

endmodule

`default_nettype wire
